// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sprite_pkg
// Purpose : Shared sprite action encoding and default animation timing.
// Revision: 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef enum logic [2:0] {
        STAND    = 3'd0,
        PUNCH    = 3'd1,
        JUMP     = 3'd2,
        CROUCH   = 3'd3,
        WALK_L   = 3'd4,
        WALK_R   = 3'd5,
        DEATH    = 3'd6,
        RESERVED = 3'd7
    } sprite_idx_t;

    typedef sprite_idx_t state_t;

    localparam int ANIM_DIV_DEF  = 4;
    localparam int JUMP_HALF_DEF = 8;
    localparam int JUMP_STEP_DEF = 2;

    function automatic logic is_locked(input sprite_idx_t s);
        return (s == PUNCH) || (s == JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/anim_frame_counter.sv
`default_nettype none
// ============================================================================
// Module  : anim_frame_counter
// Purpose : ANIM_DIV tick divider feeding a 2-bit frame counter (wrap/saturate).
// Revision: 1.0 - initial release
// ============================================================================
module anim_frame_counter
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV = ANIM_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_clear,
    input  logic       i_sat,
    output logic [1:0] o_frame_num,
    output logic       o_wrap
);

    localparam int                 c_div_w   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(ANIM_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_frame;

    // Wrap ignores i_clear so the owner can decide on clearing without a loop.
    assign o_wrap      = i_en && (r_div == c_div_max);
    assign o_frame_num = r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_frame <= 2'd0;
        end else if (i_en) begin
            if (i_clear) begin
                r_div   <= '0;
                r_frame <= 2'd0;
            end else if (r_div == c_div_max) begin
                r_div <= '0;
                if (!(i_sat && (r_frame == 2'd3))) begin
                    r_frame <= r_frame + 2'd1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
// Module  : sprite_animator
// Purpose : Turns per-frame action indices into timed sprite animations.
//           Optional macro SPRITE_PUNCH_CANCEL_EN lets a jump abort a punch.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int ANIM_DIV  = ANIM_DIV_DEF,
    parameter int JUMP_HALF = JUMP_HALF_DEF,
    parameter int JUMP_STEP = JUMP_STEP_DEF,
    parameter int OFS_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_tick,
    input  logic [2:0]       i_sprite_index,
    output logic [2:0]       o_sprite_sel,
    output logic [1:0]       o_frame_num,
    output logic [4:0]       o_rom_slot,
    output logic [OFS_W-1:0] o_jump_offset,
    output logic             o_busy,
    output logic             o_dead,
    output logic             o_death_done
);

`ifdef SPRITE_PUNCH_CANCEL_EN
    localparam bit c_cancel = 1'b1;
`else
    localparam bit c_cancel = 1'b0;
`endif

    localparam logic [OFS_W-1:0] c_step = OFS_W'(JUMP_STEP);
    localparam logic [OFS_W-1:0] c_peak = OFS_W'(JUMP_HALF * JUMP_STEP);

    generate
        if (JUMP_HALF * JUMP_STEP > (2 ** OFS_W) - 1) begin : g_peak_overflow
            $error("sprite_animator: jump peak does not fit OFS_W");
        end
    endgenerate

    state_t             r_state, w_state_nxt;
    logic [OFS_W-1:0]   r_ofs, w_ofs_nxt;
    logic               r_desc, w_desc_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_dead, w_dead_nxt;
    logic               r_done, w_done_nxt;
    logic               w_clr, w_sample, w_wrap;
    logic [1:0]         w_cnt_frame;
    sprite_idx_t        w_idx;

    assign w_idx = (i_sprite_index == RESERVED) ? STAND : sprite_idx_t'(i_sprite_index);

    anim_frame_counter #(
        .ANIM_DIV    (ANIM_DIV)
    ) u_frame_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (i_frame_tick),
        .i_clear     (w_clr),
        .i_sat       (r_state == DEATH),
        .o_frame_num (w_cnt_frame),
        .o_wrap      (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ofs_nxt   = r_ofs;
        w_desc_nxt  = r_desc;
        w_busy_nxt  = r_busy;
        w_dead_nxt  = r_dead;
        w_done_nxt  = r_done;
        w_clr       = 1'b0;
        w_sample    = 1'b0;

        case (r_state)
            DEATH: begin
                if (w_wrap && (w_cnt_frame >= 2'd2)) begin
                    w_done_nxt = 1'b1;
                end
            end
            PUNCH: begin
                if (w_wrap && (w_cnt_frame == 2'd3)) begin
                    w_sample = 1'b1;
                end else if (c_cancel && (w_idx == JUMP)) begin
                    w_sample = 1'b1;
                end
            end
            JUMP: begin
                if (!r_desc) begin
                    if (r_ofs == c_peak) begin
                        w_desc_nxt = 1'b1;
                        w_ofs_nxt  = r_ofs - c_step;
                    end else begin
                        w_ofs_nxt  = r_ofs + c_step;
                    end
                end else if (r_ofs == c_step) begin
                    w_sample = 1'b1;
                end else begin
                    w_ofs_nxt = r_ofs - c_step;
                end
            end
            default: w_sample = 1'b1;
        endcase

        if (w_sample) begin
            w_state_nxt = w_idx;
            // Holding the same walk direction keeps the stride cycle running.
            w_clr       = !(((w_idx == WALK_L) || (w_idx == WALK_R)) && (w_idx == r_state));
            w_ofs_nxt   = (w_idx == JUMP) ? c_step : '0;
            w_desc_nxt  = 1'b0;
            w_busy_nxt  = is_locked(w_idx);
        end

        if ((w_idx == DEATH) && (r_state != DEATH)) begin
            w_state_nxt = DEATH;
            w_clr       = 1'b1;
            w_ofs_nxt   = '0;
            w_desc_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_dead_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STAND;
            r_ofs   <= '0;
            r_desc  <= 1'b0;
            r_busy  <= 1'b0;
            r_dead  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_frame_tick) begin
            r_state <= w_state_nxt;
            r_ofs   <= w_ofs_nxt;
            r_desc  <= w_desc_nxt;
            r_busy  <= w_busy_nxt;
            r_dead  <= w_dead_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_sprite_sel  = r_state;
    assign o_frame_num   = (r_state == JUMP) ? {1'b0, r_desc} : w_cnt_frame;
    assign o_rom_slot    = {o_sprite_sel, o_frame_num};
    assign o_jump_offset = r_ofs;
    assign o_busy        = r_busy;
    assign o_dead        = r_dead;
    assign o_death_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_animator
// Purpose : Directed and random stimulus against a tick-count reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprite_animator;
    import sprite_pkg::*;

    localparam int DIV  = 4;
    localparam int HALF = 8;
    localparam int STEP = 2;
    localparam int OW   = 8;
`ifdef SPRITE_PUNCH_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick  = 1'b0;
    logic [2:0]    idx   = 3'd0;
    logic [2:0]    sel;
    logic [1:0]    frame;
    logic [4:0]    rom;
    logic [OW-1:0] ofs;
    logic          busy, dead, done;

    int n_cmp = 0;
    int n_err = 0;
    int ms    = 0;  // model action
    int mk    = 0;  // ticks since the action was entered (entry tick = 1)

    sprite_animator #(
        .ANIM_DIV       (DIV),
        .JUMP_HALF      (HALF),
        .JUMP_STEP      (STEP),
        .OFS_W          (OW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_frame_tick   (tick),
        .i_sprite_index (idx),
        .o_sprite_sel   (sel),
        .o_frame_num    (frame),
        .o_rom_slot     (rom),
        .o_jump_offset  (ofs),
        .o_busy         (busy),
        .o_dead         (dead),
        .o_death_done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int e_frame();
        case (ms)
            1:       return (mk - 1) / DIV;
            2:       return (mk > HALF) ? 1 : 0;
            4, 5:    return ((mk - 1) / DIV) % 4;
            6:       return ((mk - 1) / DIV > 3) ? 3 : (mk - 1) / DIV;
            default: return 0;
        endcase
    endfunction

    function automatic int e_ofs();
        if (ms != 2) return 0;
        return (mk <= HALF) ? mk * STEP : (2 * HALF - mk) * STEP;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".sel"},   int'(sel),  ms);
        chk({where, ".frame"}, int'(frame), e_frame());
        chk({where, ".rom"},   int'(rom),  ms * 4 + e_frame());
        chk({where, ".ofs"},   int'(ofs),  e_ofs());
        chk({where, ".busy"},  int'(busy), (ms == 1 || ms == 2) ? 1 : 0);
        chk({where, ".dead"},  int'(dead), (ms == 6) ? 1 : 0);
        chk({where, ".done"},  int'(done), (ms == 6 && mk - 1 >= 3 * DIV) ? 1 : 0);
    endtask

    task automatic model_tick(input int i);
        int v;
        bit enter;
        v     = (i == 7) ? 0 : i;
        enter = 1'b0;
        if (ms == 6) begin
            mk++;
        end else if (v == 6) begin
            enter = 1'b1;
        end else begin
            case (ms)
                1:       if (mk == 4 * DIV || (CANCEL && v == 2)) enter = 1'b1; else mk++;
                2:       if (mk + 1 == 2 * HALF) enter = 1'b1; else mk++;
                4, 5:    if (v == ms) mk++; else enter = 1'b1;
                default: enter = 1'b1;
            endcase
        end
        if (enter) begin
            ms = v;
            mk = 1;
        end
    endtask

    task automatic do_tick(input int i);
        @(negedge clk);
        idx  = 3'(i);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_tick(i);
        check_all("tick");
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            idx = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check_all("hold");
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        ms = 0;
        mk = 0;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int v, run;

        // Idle STAND, then a single-tick punch that must run its full length.
        do_reset();
        repeat (10) do_tick(0);
        do_tick(1);
        repeat (17) do_tick(0);
        // Held punch: second punch follows with no STAND gap.
        repeat (21) do_tick(1);
        do_tick(0);
        do_tick(0);
        // Full jump arc.
        do_tick(2);
        repeat (16) do_tick(0);
        // Walk left for 9 ticks, then turn right.
        repeat (9) do_tick(4);
        do_tick(5);
        do_tick(5);
        // Punch with a jump request on its fifth tick.
        do_tick(1);
        repeat (3) do_tick(0);
        do_tick(2);
        repeat (20) do_tick(0);
        // Death mid-jump at offset 10, then ignored inputs and a reset mid-death.
        do_tick(2);
        repeat (4) do_tick(0);
        chk("ofs_before_death", int'(ofs), 10);
        do_tick(6);
        repeat (14) do_tick($urandom_range(0, 7));
        do_reset();

        // Random held-input segments with occasional idle gaps between ticks.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            run = 0;
            v   = 0;
            for (int t = 0; t < 300; t++) begin
                if (run == 0) begin
                    v = $urandom_range(0, 7);
                    if (v == 6 && $urandom_range(0, 19) != 0) v = 7;
                    run = $urandom_range(1, 20);
                end
                run--;
                do_tick(v);
                idle($urandom_range(0, 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
